instr_mem_responder: RTL and testbench
======================================

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 32-bit instruction words held.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning log2(DEPTH) and the width of the internal word index.
REQ-003 SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have fetch_req  input  1  fetch request, level, held by the requester until fetch_ack.
REQ-006 SHALL have PC  input  16  word address of the requested instruction, stable while fetch_req is high.
REQ-007 SHALL have instruction_from_ram  output  32  fetched instruction word, registered.
REQ-008 SHALL have fetch_ack  output  1  single-cycle pulse; instruction_from_ram is valid while it is high.
REQ-009 SHALL have addr_fault  output  1  single-cycle pulse coincident with fetch_ack when PC >= DEPTH.
REQ-010 SHALL have load_start  input  1  single-cycle pulse that clears the program-load pointers.
REQ-011 SHALL have load_valid  input  1  load_byte is presented this cycle.
REQ-012 SHALL have load_byte  input  8  program image byte, little-endian within each word.
REQ-013 SHALL have load_ready  output  1  a byte is accepted when load_valid and load_ready are both high.
REQ-014 SHALL have words_loaded  output  ADDR_W+1  count of words written since the last load_start, saturating at DEPTH.

Function
REQ-015 SHALL implement a fetch FSM with states IDLE, READ and RESP; no other states are reachable.
REQ-016 IDLE -> READ when fetch_req=1 and no word write occurs this cycle; PC is registered on this transition.
REQ-017 READ -> RESP unconditionally; the synchronous memory read of the registered PC occurs in READ.
REQ-018 RESP -> IDLE unconditionally; fetch_ack=1 and instruction_from_ram updated only in RESP.
REQ-019 Latency: fetch_req sampled high at edge N in IDLE shall produce fetch_ack high in the cycle after edge N+2.
REQ-020 If fetch_req is still high in the IDLE cycle after RESP, it SHALL be treated as a new request; maximum throughput is one fetch per 3 cycles.
REQ-021 When PC >= DEPTH: instruction_from_ram=32'h0000_0000 (NOP), addr_fault=1 with fetch_ack, and memory is not read.
REQ-022 instruction_from_ram SHALL hold its last value outside RESP and never drive Z or X after reset.
REQ-023 The byte assembler SHALL place accepted bytes 0..3 into bits [7:0], [15:8], [23:16] and [31:24], then write the word to mem[wr_ptr] in the cycle the 4th byte is accepted.
REQ-024 wr_ptr SHALL increment after each word write and wrap from DEPTH-1 to 0; words_loaded SHALL stop at DEPTH.
REQ-025 load_ready=0 while the FSM is in READ (single-port memory); load_ready=1 otherwise.
REQ-026 If a word write and fetch_req coincide in IDLE, the write SHALL win and the fetch SHALL be deferred one cycle.
REQ-027 load_start SHALL clear the byte count, wr_ptr and words_loaded; a byte accepted in the same cycle SHALL become byte 0 of word 0.
REQ-028 A partial word (fewer than 4 bytes) SHALL never be written; load_start discards it.
REQ-029 A fetch from an address written in the same cycle the FSM enters READ SHALL return the new word.

Reset
REQ-030 On rst=0: FSM=IDLE, fetch_ack=0, addr_fault=0, instruction_from_ram=32'h0, byte count=0, wr_ptr=0, words_loaded=0.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 Reset mid-fetch (READ or RESP) SHALL abort the fetch without an ack; the requester re-issues.
REQ-033 Release of rst SHALL be usable on any clk edge; the first request is accepted on the first edge after release.

Structure
REQ-034 A shared package instr_mem_pkg SHALL hold the FSM state typedef, default DEPTH/ADDR_W and the NOP constant 32'h0.
REQ-035 The byte-to-word packer SHALL be a separate sub-module named byte_assembler; memory array and FSM SHALL stay in the top.

Verification
REQ-036 Load bytes 78,56,34,12 -> mem[0]=32'h12345678; fetch PC=0 -> ack 3 cycles later with 32'h12345678, words_loaded=1.
REQ-037 Fetch PC=16'h0100 with DEPTH=256 -> instruction_from_ram=32'h0, addr_fault=1 with fetch_ack.
REQ-038 Hold fetch_req high for 9 cycles -> exactly 3 fetch_ack pulses, spaced 3 cycles apart.
REQ-039 Complete a 4th byte in the same IDLE cycle as fetch_req -> word written, ack 1 cycle later than REQ-019, load_ready low during READ.
REQ-040 Load 257 words with DEPTH=256 -> word 256 overwrites mem[0], words_loaded=256; load 2 bytes then load_start -> no write.
REQ-041 Assert rst=0 during READ -> no fetch_ack, all outputs at reset values; after release, fetch PC=0 -> correct word.

Source files
------------

// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared types and constants for the instruction memory responder
package instr_mem_pkg;

    localparam int DEFAULT_DEPTH  = 256;
    localparam int DEFAULT_ADDR_W = 8;
    localparam int PC_W           = 16;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_mem_responder_if.sv
// rtl/instr_mem_responder_if.sv - fetch and program-load signal bundle
interface instr_mem_responder_if #(
    parameter int ADDR_W = instr_mem_pkg::DEFAULT_ADDR_W
);
    logic                          fetch_req;
    logic [instr_mem_pkg::PC_W-1:0] PC;
    logic [31:0]                   instruction_from_ram;
    logic                          fetch_ack;
    logic                          addr_fault;
    logic                          load_start;
    logic                          load_valid;
    logic [7:0]                    load_byte;
    logic                          load_ready;
    logic [ADDR_W:0]               words_loaded;

    modport master (
        output fetch_req, PC, load_start, load_valid, load_byte,
        input  instruction_from_ram, fetch_ack, addr_fault, load_ready, words_loaded
    );

    modport slave (
        input  fetch_req, PC, load_start, load_valid, load_byte,
        output instruction_from_ram, fetch_ack, addr_fault, load_ready, words_loaded
    );
endinterface

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - packs little-endian program bytes into 32-bit words
module byte_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        accept,
    input  logic [7:0]  load_byte,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  cnt_q;
    logic [23:0] lo_q;

    // The 4th byte is never stored; it goes straight into the word being written.
    assign word      = {load_byte, lo_q};
    assign word_done = accept && (cnt_q == 2'd3) && !load_start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 2'd0;
            lo_q  <= 24'h0;
        end else if (load_start) begin
            cnt_q <= accept ? 2'd1 : 2'd0;
            lo_q  <= accept ? {16'h0, load_byte} : 24'h0;
        end else if (accept) begin
            cnt_q <= cnt_q + 2'd1;
            case (cnt_q)
                2'd0:    lo_q[7:0]   <= load_byte;
                2'd1:    lo_q[15:8]  <= load_byte;
                2'd2:    lo_q[23:16] <= load_byte;
                default: lo_q        <= lo_q;
            endcase
        end
    end

endmodule

// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - single-port instruction memory with fetch FSM and byte loader
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_mem_responder_if.slave  bus
);

    localparam logic [31:0]       DEPTH_U   = DEPTH;
    localparam logic [ADDR_W:0]   WORDS_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

    fetch_state_t      state_q, state_d;
    logic [PC_W-1:0]   pc_q;
    logic [31:0]       mem [DEPTH];
    logic [31:0]       rdata_q;
    logic [31:0]       instr_q;
    logic              ack_q;
    logic              fault_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W:0]   words_q;

    logic              accept;
    logic              word_done;
    logic [31:0]       asm_word;
    logic              pc_fault;
    logic              load_ready;
    logic              rd_en;
    logic              resp;
    logic              take_pc;

    assign accept   = bus.load_valid && load_ready;
    assign pc_fault = {16'h0, pc_q} >= DEPTH_U;
    assign take_pc  = (state_q == ST_IDLE) && (state_d == ST_READ);

    byte_assembler u_byte_assembler (
        .clk        (clk),
        .rst        (rst),
        .load_start (bus.load_start),
        .accept     (accept),
        .load_byte  (bus.load_byte),
        .word       (asm_word),
        .word_done  (word_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A word write owns the single port this cycle, so the fetch waits in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.fetch_req && !word_done) state_d = ST_READ;
            ST_READ: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load_ready = 1'b1;
        rd_en      = 1'b0;
        resp       = 1'b0;
        case (state_q)
            ST_READ: begin
                load_ready = 1'b0;
                rd_en      = !pc_fault;
            end
            ST_RESP: resp = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q    <= '0;
            rdata_q <= NOP_INSTR;
            instr_q <= NOP_INSTR;
            ack_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            ack_q   <= resp;
            fault_q <= resp && pc_fault;
            if (take_pc) pc_q <= bus.PC;
            if (rd_en) rdata_q <= mem[pc_q[ADDR_W-1:0]];
            if (resp) instr_q <= pc_fault ? NOP_INSTR : rdata_q;
        end
    end

    // Contents survive reset so a program image is not lost across a core reset.
    always_ff @(posedge clk) begin
        if (word_done) mem[wr_ptr_q] <= asm_word;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            words_q  <= '0;
        end else if (bus.load_start) begin
            wr_ptr_q <= '0;
            words_q  <= '0;
        end else if (word_done) begin
            wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
            if (words_q != WORDS_MAX) words_q <= words_q + 1'b1;
        end
    end

    assign bus.instruction_from_ram = instr_q;
    assign bus.fetch_ack            = ack_q;
    assign bus.addr_fault           = fault_q;
    assign bus.load_ready           = load_ready;
    assign bus.words_loaded         = words_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb/tb_instr_mem_responder.sv - directed self-checking bench for instr_mem_responder
module tb_instr_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    instr_mem_responder_if #(.ADDR_W(8)) bus ();

    instr_mem_responder #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.load_valid = 1'b1;
        bus.load_byte  = b;
        cyc();
        bus.load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.load_start = 1'b1;
        cyc();
        bus.load_start = 1'b0;
    endtask

    task automatic do_fetch(input logic [15:0] pc, output logic [31:0] data,
                            output logic fault, output int lat);
        bus.fetch_req = 1'b1;
        bus.PC        = pc;
        lat = 0; data = 32'hFFFF_FFFF; fault = 1'bx;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (bus.fetch_ack === 1'b1) begin
                lat = i; data = bus.instruction_from_ram; fault = bus.addr_fault;
                break;
            end
        end
        bus.fetch_req = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.fetch_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%0h exp=0", bus.fetch_ack); end
        checks++; if (bus.addr_fault !== 1'b0) begin failures++; $display("FAIL reset_fault got=%0h exp=0", bus.addr_fault); end
        checks++; if (bus.instruction_from_ram !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus.instruction_from_ram); end
        checks++; if (bus.words_loaded !== 9'd0) begin failures++; $display("FAIL reset_words got=%0d exp=0", bus.words_loaded); end
        checks++; if (bus.load_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0h exp=1", bus.load_ready); end
    endtask

    task automatic test_load_fetch();
        logic [31:0] d; logic f; int lat;
        pulse_start();
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        checks++; if (bus.words_loaded !== 9'd1) begin failures++; $display("FAIL load_words1 got=%0d exp=1", bus.words_loaded); end
        do_fetch(16'h0000, d, f, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL fetch0_latency got=%0d exp=3", lat); end
        checks++; if (d !== 32'h1234_5678) begin failures++; $display("FAIL fetch0_data got=%h exp=12345678", d); end
        checks++; if (f !== 1'b0) begin failures++; $display("FAIL fetch0_fault got=%0h exp=0", f); end
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        checks++; if (bus.words_loaded !== 9'd2) begin failures++; $display("FAIL load_words2 got=%0d exp=2", bus.words_loaded); end
        do_fetch(16'h0001, d, f, lat);
        checks++; if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL fetch1_data got=%h exp=deadbeef", d); end
        cyc();
        checks++; if (bus.fetch_ack !== 1'b0) begin failures++; $display("FAIL ack_single_pulse got=%0h exp=0", bus.fetch_ack); end
    endtask

    task automatic test_addr_fault();
        logic [31:0] d; logic f; int lat;
        do_fetch(16'h0100, d, f, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL fault_latency got=%0d exp=3", lat); end
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL fault_data got=%h exp=0", d); end
        checks++; if (f !== 1'b1) begin failures++; $display("FAIL fault_flag got=%0h exp=1", f); end
        cyc();
        checks++; if (bus.addr_fault !== 1'b0) begin failures++; $display("FAIL fault_pulse got=%0h exp=0", bus.addr_fault); end
        checks++; if (bus.instruction_from_ram !== 32'h0) begin failures++; $display("FAIL fault_hold got=%h exp=0", bus.instruction_from_ram); end
    endtask

    task automatic test_back_to_back();
        int n_ack = 0; int first = 0; int last = 0; int bad_data = 0;
        bus.fetch_req = 1'b1;
        bus.PC        = 16'h0000;
        for (int i = 1; i <= 9; i++) begin
            cyc();
            if (bus.fetch_ack === 1'b1) begin
                n_ack++;
                if (first == 0) first = i;
                last = i;
                if (bus.instruction_from_ram !== 32'h1234_5678) bad_data++;
            end
        end
        bus.fetch_req = 1'b0;
        checks++; if (n_ack !== 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", n_ack); end
        checks++; if (first !== 3 || last !== 9) begin failures++; $display("FAIL b2b_spacing got=%0d,%0d exp=3,9", first, last); end
        checks++; if (bad_data !== 0) begin failures++; $display("FAIL b2b_data got=%0d bad exp=0", bad_data); end
    endtask

    task automatic test_write_collision();
        pulse_start();
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        bus.load_valid = 1'b1; bus.load_byte = 8'h44;
        bus.fetch_req  = 1'b1; bus.PC = 16'h0000;
        cyc();
        bus.load_valid = 1'b0;
        checks++; if (bus.load_ready !== 1'b1 || bus.fetch_ack !== 1'b0) begin failures++; $display("FAIL coll_deferred got=ready%0h,ack%0h exp=ready1,ack0", bus.load_ready, bus.fetch_ack); end
        cyc();
        checks++; if (bus.load_ready !== 1'b0) begin failures++; $display("FAIL coll_ready_read got=%0h exp=0", bus.load_ready); end
        cyc();
        checks++; if (bus.load_ready !== 1'b1 || bus.fetch_ack !== 1'b0) begin failures++; $display("FAIL coll_resp got=ready%0h,ack%0h exp=ready1,ack0", bus.load_ready, bus.fetch_ack); end
        cyc();
        bus.fetch_req = 1'b0;
        checks++; if (bus.fetch_ack !== 1'b1) begin failures++; $display("FAIL coll_ack got=%0h exp=1", bus.fetch_ack); end
        checks++; if (bus.instruction_from_ram !== 32'h4433_2211) begin failures++; $display("FAIL coll_data got=%h exp=44332211", bus.instruction_from_ram); end
        checks++; if (bus.words_loaded !== 9'd1) begin failures++; $display("FAIL coll_words got=%0d exp=1", bus.words_loaded); end
    endtask

    task automatic test_wrap();
        logic [31:0] d; logic f; int lat; logic [15:0] k16;
        pulse_start();
        for (int k = 0; k <= 256; k++) begin
            k16 = 16'(k);
            send_byte(k16[7:0]); send_byte(k16[15:8]); send_byte(8'h00); send_byte(8'h10);
        end
        checks++; if (bus.words_loaded !== 9'd256) begin failures++; $display("FAIL wrap_words got=%0d exp=256", bus.words_loaded); end
        do_fetch(16'h0000, d, f, lat);
        checks++; if (d !== 32'h1000_0100) begin failures++; $display("FAIL wrap_mem0 got=%h exp=10000100", d); end
        do_fetch(16'h00FF, d, f, lat);
        checks++; if (d !== 32'h1000_00FF) begin failures++; $display("FAIL wrap_mem255 got=%h exp=100000ff", d); end
        send_byte(8'hAA); send_byte(8'hBB);
        pulse_start();
        checks++; if (bus.words_loaded !== 9'd0) begin failures++; $display("FAIL partial_words got=%0d exp=0", bus.words_loaded); end
        do_fetch(16'h0000, d, f, lat);
        checks++; if (d !== 32'h1000_0100) begin failures++; $display("FAIL partial_nowrite got=%h exp=10000100", d); end
        bus.load_start = 1'b1;
        send_byte(8'h01);
        bus.load_start = 1'b0;
        send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        do_fetch(16'h0000, d, f, lat);
        checks++; if (d !== 32'h0403_0201) begin failures++; $display("FAIL start_byte0 got=%h exp=04030201", d); end
        checks++; if (bus.words_loaded !== 9'd1) begin failures++; $display("FAIL start_words got=%0d exp=1", bus.words_loaded); end
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] d; logic f; int lat; int acks = 0;
        bus.fetch_req = 1'b1; bus.PC = 16'h0001;
        cyc();
        checks++; if (bus.load_ready !== 1'b0) begin failures++; $display("FAIL rmf_in_read got=%0h exp=0", bus.load_ready); end
        rst = 1'b0;
        #1;
        bus.fetch_req = 1'b0;
        checks++; if (bus.instruction_from_ram !== 32'h0 || bus.fetch_ack !== 1'b0 || bus.addr_fault !== 1'b0) begin failures++; $display("FAIL rmf_outputs got=%h,%0h,%0h exp=0,0,0", bus.instruction_from_ram, bus.fetch_ack, bus.addr_fault); end
        checks++; if (bus.words_loaded !== 9'd0 || bus.load_ready !== 1'b1) begin failures++; $display("FAIL rmf_load got=%0d,%0h exp=0,1", bus.words_loaded, bus.load_ready); end
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (bus.fetch_ack !== 1'b0) acks++;
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (bus.fetch_ack !== 1'b0) acks++;
        end
        checks++; if (acks !== 0) begin failures++; $display("FAIL rmf_no_ack got=%0d exp=0", acks); end
        do_fetch(16'h0000, d, f, lat);
        checks++; if (lat !== 3 || d !== 32'h0403_0201) begin failures++; $display("FAIL rmf_refetch got=%0d,%h exp=3,04030201", lat, d); end
    endtask

    initial begin
        bus.fetch_req  = 1'b0;
        bus.PC         = 16'h0;
        bus.load_start = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_byte  = 8'h0;
        rst = 1'b0;
        cyc(); cyc();
        rst = 1'b1;
        test_reset();
        test_load_fetch();
        test_addr_fault();
        test_back_to_back();
        test_write_collision();
        test_wrap();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
